// File: rtl/icb_splitter.sv
// 1-master / 2-slave ICB address splitter with in-order responses and a local
// error responder for unmapped addresses.
module icb_splitter #(
  parameter int          OT_DEPTH = 2,
  parameter logic [31:0] S0_BASE  = 32'h2000_0000,
  parameter logic [31:0] S0_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE  = 32'h1000_0000,
  parameter logic [31:0] S1_MASK  = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_icb_cmd_valid,
  output logic        m_icb_cmd_ready,
  input  logic [31:0] m_icb_cmd_addr,
  input  logic        m_icb_cmd_read,
  input  logic [31:0] m_icb_cmd_wdata,
  input  logic [3:0]  m_icb_cmd_wmask,
  output logic        m_icb_rsp_valid,
  input  logic        m_icb_rsp_ready,
  output logic        m_icb_rsp_err,
  output logic [31:0] m_icb_rsp_rdata,
  output logic        s0_icb_cmd_valid,
  input  logic        s0_icb_cmd_ready,
  output logic [31:0] s0_icb_cmd_addr,
  output logic        s0_icb_cmd_read,
  output logic [31:0] s0_icb_cmd_wdata,
  output logic [3:0]  s0_icb_cmd_wmask,
  input  logic        s0_icb_rsp_valid,
  output logic        s0_icb_rsp_ready,
  input  logic        s0_icb_rsp_err,
  input  logic [31:0] s0_icb_rsp_rdata,
  output logic        s1_icb_cmd_valid,
  input  logic        s1_icb_cmd_ready,
  output logic [31:0] s1_icb_cmd_addr,
  output logic        s1_icb_cmd_read,
  output logic [31:0] s1_icb_cmd_wdata,
  output logic [3:0]  s1_icb_cmd_wmask,
  input  logic        s1_icb_rsp_valid,
  output logic        s1_icb_rsp_ready,
  input  logic        s1_icb_rsp_err,
  input  logic [31:0] s1_icb_rsp_rdata
);

  localparam int CW = $clog2(OT_DEPTH + 1);
  localparam logic [CW-1:0] OT_MAX = CW'(OT_DEPTH);

  typedef enum logic [1:0] {
    TGT_S0  = 2'd0,
    TGT_S1  = 2'd1,
    TGT_ERR = 2'd2
  } tgt_e;

  logic [CW-1:0] cnt;
  tgt_e          cur_tgt;
  tgt_e          tgt;
  logic          err_pend;
  logic          ok;
  logic          cmd_hs;
  logic          rsp_hs;

  always_comb begin
    tgt = TGT_ERR;
    if ((m_icb_cmd_addr & S0_MASK) == S0_BASE) tgt = TGT_S0;
    else if ((m_icb_cmd_addr & S1_MASK) == S1_BASE) tgt = TGT_S1;
  end

  // A target switch waits for a full drain, so response order needs no FIFO.
  assign ok = (cnt < OT_MAX) && ((cnt == '0) || (tgt == cur_tgt));

  always_comb begin
    s0_icb_cmd_valid = 1'b0;
    s1_icb_cmd_valid = 1'b0;
    m_icb_cmd_ready  = 1'b0;
    case (tgt)
      TGT_S0: begin
        s0_icb_cmd_valid = m_icb_cmd_valid && ok;
        m_icb_cmd_ready  = ok && s0_icb_cmd_ready;
      end
      TGT_S1: begin
        s1_icb_cmd_valid = m_icb_cmd_valid && ok;
        m_icb_cmd_ready  = ok && s1_icb_cmd_ready;
      end
      default: m_icb_cmd_ready = ok && !err_pend;
    endcase
  end

  assign s0_icb_cmd_addr  = m_icb_cmd_addr;
  assign s0_icb_cmd_read  = m_icb_cmd_read;
  assign s0_icb_cmd_wdata = m_icb_cmd_wdata;
  assign s0_icb_cmd_wmask = m_icb_cmd_wmask;
  assign s1_icb_cmd_addr  = m_icb_cmd_addr;
  assign s1_icb_cmd_read  = m_icb_cmd_read;
  assign s1_icb_cmd_wdata = m_icb_cmd_wdata;
  assign s1_icb_cmd_wmask = m_icb_cmd_wmask;

  always_comb begin
    m_icb_rsp_valid  = 1'b0;
    m_icb_rsp_err    = 1'b0;
    m_icb_rsp_rdata  = '0;
    s0_icb_rsp_ready = 1'b0;
    s1_icb_rsp_ready = 1'b0;
    if (cnt != '0) begin
      case (cur_tgt)
        TGT_S0: begin
          m_icb_rsp_valid  = s0_icb_rsp_valid;
          m_icb_rsp_err    = s0_icb_rsp_err;
          m_icb_rsp_rdata  = s0_icb_rsp_rdata;
          s0_icb_rsp_ready = m_icb_rsp_ready;
        end
        TGT_S1: begin
          m_icb_rsp_valid  = s1_icb_rsp_valid;
          m_icb_rsp_err    = s1_icb_rsp_err;
          m_icb_rsp_rdata  = s1_icb_rsp_rdata;
          s1_icb_rsp_ready = m_icb_rsp_ready;
        end
        default: begin
          m_icb_rsp_valid = err_pend;
          m_icb_rsp_err   = 1'b1;
        end
      endcase
    end
  end

  assign cmd_hs = m_icb_cmd_valid && m_icb_cmd_ready;
  assign rsp_hs = m_icb_rsp_valid && m_icb_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      cur_tgt  <= TGT_S0;
      err_pend <= 1'b0;
    end else begin
      if (cmd_hs) cur_tgt <= tgt;
      if (cmd_hs && (tgt == TGT_ERR)) err_pend <= 1'b1;
      else if (rsp_hs && (cur_tgt == TGT_ERR)) err_pend <= 1'b0;
      if (cmd_hs && !rsp_hs) cnt <= cnt + 1'b1;
      else if (!cmd_hs && rsp_hs) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_icb_splitter.sv
// Directed bench for icb_splitter: queue-based reference model checked every
// cycle, plus hand-computed spot checks.
module tb_icb_splitter;

  localparam int OT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_icb_cmd_valid, m_icb_cmd_ready;
  logic [31:0] m_icb_cmd_addr;
  logic        m_icb_cmd_read;
  logic [31:0] m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_rsp_valid, m_icb_rsp_ready, m_icb_rsp_err;
  logic [31:0] m_icb_rsp_rdata;
  logic        s0_icb_cmd_valid, s0_icb_cmd_ready, s0_icb_cmd_read;
  logic [31:0] s0_icb_cmd_addr, s0_icb_cmd_wdata;
  logic [3:0]  s0_icb_cmd_wmask;
  logic        s0_icb_rsp_valid, s0_icb_rsp_ready, s0_icb_rsp_err;
  logic [31:0] s0_icb_rsp_rdata;
  logic        s1_icb_cmd_valid, s1_icb_cmd_ready, s1_icb_cmd_read;
  logic [31:0] s1_icb_cmd_addr, s1_icb_cmd_wdata;
  logic [3:0]  s1_icb_cmd_wmask;
  logic        s1_icb_rsp_valid, s1_icb_rsp_ready, s1_icb_rsp_err;
  logic [31:0] s1_icb_rsp_rdata;

  int checks = 0;
  int errors = 0;
  int q[$];

  always #5 clk = ~clk;

  icb_splitter #(
    .OT_DEPTH(OT),
    .S0_BASE(32'h2000_0000),
    .S0_MASK(32'hFFFF_0000),
    .S1_BASE(32'h1000_0000),
    .S1_MASK(32'hF000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
    .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
    .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
    .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
    .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata),
    .s0_icb_cmd_valid(s0_icb_cmd_valid), .s0_icb_cmd_ready(s0_icb_cmd_ready),
    .s0_icb_cmd_addr(s0_icb_cmd_addr), .s0_icb_cmd_read(s0_icb_cmd_read),
    .s0_icb_cmd_wdata(s0_icb_cmd_wdata), .s0_icb_cmd_wmask(s0_icb_cmd_wmask),
    .s0_icb_rsp_valid(s0_icb_rsp_valid), .s0_icb_rsp_ready(s0_icb_rsp_ready),
    .s0_icb_rsp_err(s0_icb_rsp_err), .s0_icb_rsp_rdata(s0_icb_rsp_rdata),
    .s1_icb_cmd_valid(s1_icb_cmd_valid), .s1_icb_cmd_ready(s1_icb_cmd_ready),
    .s1_icb_cmd_addr(s1_icb_cmd_addr), .s1_icb_cmd_read(s1_icb_cmd_read),
    .s1_icb_cmd_wdata(s1_icb_cmd_wdata), .s1_icb_cmd_wmask(s1_icb_cmd_wmask),
    .s1_icb_rsp_valid(s1_icb_rsp_valid), .s1_icb_rsp_ready(s1_icb_rsp_ready),
    .s1_icb_rsp_err(s1_icb_rsp_err), .s1_icb_rsp_rdata(s1_icb_rsp_rdata)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    if ((a & 32'hFFFF_0000) == 32'h2000_0000) return 0;
    if ((a & 32'hF000_0000) == 32'h1000_0000) return 1;
    return 2;
  endfunction

  // Reference model: queue of targets of outstanding commands, oldest first.
  always @(negedge clk) begin
    int t, n, head;
    logic ok, e_s0v, e_s1v, e_rdy, e_rv, e_err, e_s0rr, e_s1rr;
    logic [31:0] e_rd;
    if (rst) q.delete();
    t    = decode(m_icb_cmd_addr);
    n    = q.size();
    head = (n > 0) ? q[0] : -1;
    ok   = (n < OT) && (n == 0 || t == head);
    e_s0v = m_icb_cmd_valid && ok && t == 0;
    e_s1v = m_icb_cmd_valid && ok && t == 1;
    if (t == 0)      e_rdy = ok && s0_icb_cmd_ready;
    else if (t == 1) e_rdy = ok && s1_icb_cmd_ready;
    else             e_rdy = ok && !(head == 2);
    e_rv = 1'b0; e_err = 1'b0; e_rd = 32'h0;
    if (head == 0)      begin e_rv = s0_icb_rsp_valid; e_err = s0_icb_rsp_err; e_rd = s0_icb_rsp_rdata; end
    else if (head == 1) begin e_rv = s1_icb_rsp_valid; e_err = s1_icb_rsp_err; e_rd = s1_icb_rsp_rdata; end
    else if (head == 2) begin e_rv = 1'b1; e_err = 1'b1; end
    e_s0rr = (head == 0) && m_icb_rsp_ready;
    e_s1rr = (head == 1) && m_icb_rsp_ready;
    chk("m_cmd_ready", {31'b0, m_icb_cmd_ready}, {31'b0, e_rdy});
    chk("s0_cmd_valid", {31'b0, s0_icb_cmd_valid}, {31'b0, e_s0v});
    chk("s1_cmd_valid", {31'b0, s1_icb_cmd_valid}, {31'b0, e_s1v});
    chk("m_rsp_valid", {31'b0, m_icb_rsp_valid}, {31'b0, e_rv});
    chk("s0_rsp_ready", {31'b0, s0_icb_rsp_ready}, {31'b0, e_s0rr});
    chk("s1_rsp_ready", {31'b0, s1_icb_rsp_ready}, {31'b0, e_s1rr});
    chk("pass_addr", s0_icb_cmd_addr ^ s1_icb_cmd_addr, 32'h0);
    chk("s0_addr", s0_icb_cmd_addr, m_icb_cmd_addr);
    chk("s1_wdata", s1_icb_cmd_wdata, m_icb_cmd_wdata);
    chk("wmask_read", {s0_icb_cmd_wmask, s1_icb_cmd_wmask, s0_icb_cmd_read, s1_icb_cmd_read},
        {m_icb_cmd_wmask, m_icb_cmd_wmask, m_icb_cmd_read, m_icb_cmd_read});
    if (e_rv) begin
      chk("m_rsp_err", {31'b0, m_icb_rsp_err}, {31'b0, e_err});
      chk("m_rsp_rdata", m_icb_rsp_rdata, e_rd);
    end
    if (!rst) begin
      if (e_rv && m_icb_rsp_ready && n > 0) void'(q.pop_front());
      if (m_icb_cmd_valid && e_rdy) q.push_back(t);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic v, input logic [31:0] a, input logic rd);
    m_icb_cmd_valid = v;
    m_icb_cmd_addr  = a;
    m_icb_cmd_read  = rd;
    m_icb_cmd_wdata = a ^ 32'hCAFE_0000;
    m_icb_cmd_wmask = rd ? 4'h0 : 4'hF;
  endtask

  logic [31:0] tbl [8] = '{32'h2000_0000, 32'h2000_0004, 32'h1000_0000, 32'h3000_0000,
                           32'h3000_0004, 32'h2000_0008, 32'h1FFF_0000, 32'h2001_0000};

  initial begin
    rst = 1'b1;
    cmd(1'b0, 32'h0, 1'b1);
    m_icb_rsp_ready  = 1'b1;
    s0_icb_cmd_ready = 1'b1; s1_icb_cmd_ready = 1'b1;
    s0_icb_rsp_valid = 1'b1; s0_icb_rsp_err = 1'b0; s0_icb_rsp_rdata = 32'h0;
    s1_icb_rsp_valid = 1'b0; s1_icb_rsp_err = 1'b0; s1_icb_rsp_rdata = 32'h0;
    #2;
    chk("rst_rsp_valid", {31'b0, m_icb_rsp_valid}, 32'h0);
    chk("rst_s0_rsp_ready", {31'b0, s0_icb_rsp_ready}, 32'h0);
    chk("rst_cmd_ready", {31'b0, m_icb_cmd_ready}, 32'h1);
    step(); step();
    rst = 1'b0;
    s0_icb_rsp_valid = 1'b0;

    // 1: single s0 read
    step();
    cmd(1'b1, 32'h2000_0010, 1'b1); #1;
    chk("t1_s0_cmd_valid", {30'b0, s0_icb_cmd_valid, s1_icb_cmd_valid}, 32'h2);
    step();
    cmd(1'b0, 32'h0, 1'b1);
    s0_icb_rsp_valid = 1'b1; s0_icb_rsp_rdata = 32'hDEAD_BEEF; #1;
    chk("t1_rdata", m_icb_rsp_rdata, 32'hDEAD_BEEF);
    chk("t1_err_valid", {30'b0, m_icb_rsp_err, m_icb_rsp_valid}, 32'h1);
    step();
    s0_icb_rsp_valid = 1'b0;

    // 2: two s1 reads fill the window, third stalls until first response
    cmd(1'b1, 32'h1000_0000, 1'b1); step();
    cmd(1'b1, 32'h1000_0004, 1'b1); step();
    cmd(1'b1, 32'h1000_0008, 1'b1); #1;
    chk("t2_stall", {31'b0, m_icb_cmd_ready}, 32'h0);
    step();
    s1_icb_rsp_valid = 1'b1; s1_icb_rsp_rdata = 32'h1; #1;
    chk("t2_stall_rsp", {30'b0, m_icb_cmd_ready, m_icb_rsp_valid}, 32'h1);
    step();
    s1_icb_rsp_rdata = 32'h2; #1;
    chk("t2_issue", {30'b0, m_icb_cmd_ready, s1_icb_cmd_valid}, 32'h3);
    step();
    cmd(1'b0, 32'h0, 1'b1);
    s1_icb_rsp_rdata = 32'h3; #1;
    chk("t2_rsp3", m_icb_rsp_rdata, 32'h3);
    step();
    s1_icb_rsp_valid = 1'b0; #1;
    chk("t2_drained", {31'b0, m_icb_rsp_valid}, 32'h0);

    // 3: target switch waits for drain
    cmd(1'b1, 32'h1000_0100, 1'b1); step();
    cmd(1'b1, 32'h2000_0000, 1'b1); #1;
    chk("t3_blocked", {30'b0, s0_icb_cmd_valid, m_icb_cmd_ready}, 32'h0);
    step();
    s1_icb_rsp_valid = 1'b1; s1_icb_rsp_rdata = 32'h77; #1;
    chk("t3_blocked_rsp", {31'b0, s0_icb_cmd_valid}, 32'h0);
    step();
    s1_icb_rsp_valid = 1'b0; #1;
    chk("t3_switch", {30'b0, s0_icb_cmd_valid, m_icb_cmd_ready}, 32'h3);
    step();
    cmd(1'b0, 32'h0, 1'b1);
    s0_icb_rsp_valid = 1'b1; s0_icb_rsp_rdata = 32'h55; #1;
    chk("t3_rdata", m_icb_rsp_rdata, 32'h55);
    step();
    s0_icb_rsp_valid = 1'b0;

    // 4: unmapped write gets a held local error response
    cmd(1'b1, 32'h3000_0000, 1'b0);
    m_icb_rsp_ready = 1'b0; #1;
    chk("t4_accept", {29'b0, m_icb_cmd_ready, s0_icb_cmd_valid, s1_icb_cmd_valid}, 32'h4);
    step();
    cmd(1'b0, 32'h0, 1'b1); #1;
    chk("t4_err_rsp", {m_icb_rsp_rdata[29:0], m_icb_rsp_valid, m_icb_rsp_err}, 32'h3);
    step(); #1;
    chk("t4_held", {30'b0, m_icb_rsp_valid, m_icb_rsp_err}, 32'h3);
    m_icb_rsp_ready = 1'b1;
    step(); #1;
    chk("t4_done", {31'b0, m_icb_rsp_valid}, 32'h0);

    // 5: simultaneous cmd and rsp handshake at cnt=1, then spurious response
    cmd(1'b1, 32'h2000_0010, 1'b1); step();
    cmd(1'b1, 32'h2000_0020, 1'b1);
    s0_icb_rsp_valid = 1'b1; s0_icb_rsp_rdata = 32'hA1; #1;
    chk("t5_both", {m_icb_rsp_rdata[29:0], m_icb_cmd_ready, m_icb_rsp_valid}, 32'h287);
    step();
    cmd(1'b0, 32'h0, 1'b1);
    s0_icb_rsp_rdata = 32'hA2; #1;
    chk("t5_second", {m_icb_rsp_rdata[30:0], m_icb_rsp_valid}, 32'h145);
    step(); #1;
    chk("t5_spurious", {30'b0, m_icb_rsp_valid, s0_icb_rsp_ready}, 32'h0);
    s0_icb_rsp_valid = 1'b0;

    // 6: reset mid-transaction
    cmd(1'b1, 32'h1000_0000, 1'b1); step();
    cmd(1'b1, 32'h1000_0004, 1'b1); step();
    cmd(1'b0, 32'h0, 1'b1);
    s1_icb_rsp_valid = 1'b1;
    rst = 1'b1; #1;
    chk("t6_rst_cnt2", {30'b0, m_icb_rsp_valid, s1_icb_rsp_ready}, 32'h0);
    step();
    rst = 1'b0; #1;
    chk("t6_after_rst", {31'b0, m_icb_rsp_valid}, 32'h0);
    s1_icb_rsp_valid = 1'b0;
    cmd(1'b1, 32'h3000_0000, 1'b0); step();
    cmd(1'b0, 32'h0, 1'b1); #1;
    chk("t6_err_pend", {31'b0, m_icb_rsp_valid}, 32'h1);
    rst = 1'b1; #1;
    chk("t6_rst_err", {31'b0, m_icb_rsp_valid}, 32'h0);
    step();
    rst = 1'b0;
    cmd(1'b1, 32'h2000_0004, 1'b1); #1;
    chk("t6_fresh_rdy", {31'b0, m_icb_cmd_ready}, 32'h1);
    step();
    cmd(1'b0, 32'h0, 1'b1);
    s0_icb_rsp_valid = 1'b1; s0_icb_rsp_rdata = 32'h600D; #1;
    chk("t6_fresh_rsp", {m_icb_rsp_rdata[29:0], m_icb_rsp_err, m_icb_rsp_valid}, 32'h18035);
    step();

    // Mixed-target stream with always-responding slaves
    s0_icb_rsp_rdata = 32'h5A5A_0000;
    s1_icb_rsp_valid = 1'b1; s1_icb_rsp_rdata = 32'hA5A5_0000; s1_icb_rsp_err = 1'b1;
    foreach (tbl[i]) begin
      int w;
      w = 0;
      cmd(1'b1, tbl[i], i[0]);
      #1;
      while (!m_icb_cmd_ready && w < 20) begin
        step(); #1;
        w++;
      end
      if (w >= 20) chk("stream_timeout", {31'b0, m_icb_cmd_ready}, 32'h1);
      step();
    end
    cmd(1'b0, 32'h0, 1'b1);
    repeat (4) step();
    s0_icb_rsp_valid = 1'b0; s1_icb_rsp_valid = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
